// File: rtl/dmem_arb_pkg.sv
// ============================================================================
// Module   : dmem_arb_pkg
// Purpose  : Shared types and default widths for the data-memory arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

package dmem_arb_pkg;

    localparam int unsigned c_ADDR_W = 10;
    localparam int unsigned c_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        DONE  = 2'd2
    } arb_state_t;

    // 0 selects m0, 1 selects m1
    typedef logic port_idx_t;

endpackage

`default_nettype wire

// File: rtl/dmem_arbiter_rr_pick2.sv
// ============================================================================
// Module   : rr_pick2
// Purpose  : Combinational two-way round-robin picker with optional lock owner.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_pick2
    import dmem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  port_idx_t  last_gnt,
    input  logic       lock_valid,
    input  port_idx_t  lock_owner,
    output port_idx_t  winner,
    output logic       any
);

    always_comb begin
        any    = |req;
        winner = 1'b0;
        if (lock_valid && req[lock_owner]) begin
            winner = lock_owner;
        end else if (&req) begin
            winner = ~last_gnt;
        end else begin
            // single requester (or none, where the value is unused)
            winner = req[1];
        end
    end

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Serialises m0/m1 accesses onto a single-port data memory using an
//            IDLE/SERVE/DONE sequencer. Optional lock: DMEM_ARB_LOCK_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = c_ADDR_W,
    parameter int DATA_W = c_DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wd,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rd,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wd,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rd,
`ifdef DMEM_ARB_LOCK_EN
    input  logic              m0_lock,
    input  logic              m1_lock,
`endif
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_rd
);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    port_idx_t         r_gnt;
    port_idx_t         r_last_gnt;
    port_idx_t         w_winner;
    logic              w_any;
    logic              w_lock_valid;
    port_idx_t         w_lock_owner;
    logic [DATA_W-1:0] r_m0_rd;
    logic [DATA_W-1:0] r_m1_rd;
    logic              w_gnt_we;
    logic [ADDR_W-1:0] w_gnt_addr;
    logic [DATA_W-1:0] w_gnt_wd;

    assign w_gnt_we   = r_gnt ? m1_we   : m0_we;
    assign w_gnt_addr = r_gnt ? m1_addr : m0_addr;
    assign w_gnt_wd   = r_gnt ? m1_wd   : m0_wd;

`ifdef DMEM_ARB_LOCK_EN
    logic      r_lock_valid;
    port_idx_t r_lock_owner;

    // Lock is re-evaluated on every completion, so one DONE with lock low releases it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_lock_valid <= 1'b0;
            r_lock_owner <= 1'b0;
        end else if (r_state == DONE) begin
            r_lock_valid <= r_gnt ? m1_lock : m0_lock;
            r_lock_owner <= r_gnt;
        end
    end

    assign w_lock_valid = r_lock_valid;
    assign w_lock_owner = r_lock_owner;
`else
    assign w_lock_valid = 1'b0;
    assign w_lock_owner = 1'b0;
`endif

    rr_pick2 u_pick (
        .req        ({m1_req, m0_req}),
        .last_gnt   (r_last_gnt),
        .lock_valid (w_lock_valid),
        .lock_owner (w_lock_owner),
        .winner     (w_winner),
        .any        (w_any)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wd      = '0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_nxt = SERVE;
                end
            end
            SERVE: begin
                w_state_nxt = DONE;
                mem_we      = w_gnt_we;
                mem_addr    = w_gnt_addr;
                mem_wd      = w_gnt_wd;
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_gnt      <= 1'b0;
            r_last_gnt <= 1'b1;
            r_m0_rd    <= '0;
            r_m1_rd    <= '0;
        end else begin
            if (r_state == IDLE && w_any) begin
                r_gnt <= w_winner;
            end
            if (r_state == SERVE) begin
                r_last_gnt <= r_gnt;
                if (!w_gnt_we) begin
                    if (r_gnt) begin
                        r_m1_rd <= mem_rd;
                    end else begin
                        r_m0_rd <= mem_rd;
                    end
                end
            end
        end
    end

    // Acks come straight from registered state so reset clears them at once.
    assign m0_ack = (r_state == DONE) && (r_gnt == 1'b0);
    assign m1_ack = (r_state == DONE) && (r_gnt == 1'b1);
    assign m0_rd  = r_m0_rd;
    assign m1_rd  = r_m1_rd;

    a_req_held: assert property (@(posedge clock) disable iff (reset)
        (r_state == SERVE) |-> (r_gnt ? m1_req : m0_req));

    a_one_ack: assert property (@(posedge clock) disable iff (reset)
        !(m0_ack && m1_ack));

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ============================================================================
// Module   : tb_dmem_arbiter
// Purpose  : Self-checking bench for dmem_arbiter: directed scenarios plus a
//            randomized run against a transaction-level reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_dmem_arbiter;

    logic        clock;
    logic        reset;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [9:0]  m0_addr, m1_addr;
    logic [31:0] m0_wd, m1_wd;
    logic        m0_ack, m1_ack;
    logic [31:0] m0_rd, m1_rd;
    logic        m0_lock, m1_lock;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    logic [31:0] ram [1024];

    int n_checks;
    int n_errors;

    dmem_arbiter #(.ADDR_W(10), .DATA_W(32)) dut (
        .clock    (clock),
        .reset    (reset),
        .m0_req   (m0_req),
        .m0_we    (m0_we),
        .m0_addr  (m0_addr),
        .m0_wd    (m0_wd),
        .m0_ack   (m0_ack),
        .m0_rd    (m0_rd),
        .m1_req   (m1_req),
        .m1_we    (m1_we),
        .m1_addr  (m1_addr),
        .m1_wd    (m1_wd),
        .m1_ack   (m1_ack),
        .m1_rd    (m1_rd),
`ifdef DMEM_ARB_LOCK_EN
        .m0_lock  (m0_lock),
        .m1_lock  (m1_lock),
`endif
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wd   (mem_wd),
        .mem_rd   (mem_rd)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Data memory: synchronous write, combinational read
    assign mem_rd = ram[mem_addr];
    initial begin
        for (int i = 0; i < 1024; i++) ram[i] = $urandom;
        ram[5] = 32'hDEADBEEF;
        ram[7] = 32'h0;
        forever begin
            @(posedge clock);
            if (mem_we) ram[mem_addr] <= mem_wd;
        end
    end

    task automatic do_reset();
        reset  = 1'b1;
        m0_req = 1'b0; m1_req = 1'b0;
        m0_lock = 1'b0; m1_lock = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        n_checks++; if (m0_ack !== 1'b0) begin n_errors++; $display("FAIL reset_m0_ack got %b want 0", m0_ack); end
        n_checks++; if (m1_ack !== 1'b0) begin n_errors++; $display("FAIL reset_m1_ack got %b want 0", m1_ack); end
        n_checks++; if (mem_we !== 1'b0) begin n_errors++; $display("FAIL reset_mem_we got %b want 0", mem_we); end
        n_checks++; if (mem_addr !== 10'h0) begin n_errors++; $display("FAIL reset_mem_addr got %h want 0", mem_addr); end
        n_checks++; if (mem_wd !== 32'h0) begin n_errors++; $display("FAIL reset_mem_wd got %h want 0", mem_wd); end
        n_checks++; if (m0_rd !== 32'h0) begin n_errors++; $display("FAIL reset_m0_rd got %h want 0", m0_rd); end
        n_checks++; if (m1_rd !== 32'h0) begin n_errors++; $display("FAIL reset_m1_rd got %h want 0", m1_rd); end
        reset = 1'b0;
    endtask

    task automatic test_read_after_reset();
        do_reset();
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 10'd5; m0_wd = 32'h0;
        @(negedge clock);
        n_checks++; if (mem_addr !== 10'd5) begin n_errors++; $display("FAIL rd_serve_addr got %h want 005", mem_addr); end
        n_checks++; if (m0_ack !== 1'b0) begin n_errors++; $display("FAIL rd_early_ack got %b want 0", m0_ack); end
        @(negedge clock);
        n_checks++; if (m0_ack !== 1'b1) begin n_errors++; $display("FAIL rd_m0_ack got %b want 1", m0_ack); end
        n_checks++; if (m0_rd !== 32'hDEADBEEF) begin n_errors++; $display("FAIL rd_m0_rd got %h want deadbeef", m0_rd); end
        n_checks++; if (m1_ack !== 1'b0) begin n_errors++; $display("FAIL rd_m1_ack got %b want 0", m1_ack); end
        m0_req = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_write_read();
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 10'h3FF; m1_wd = 32'h12345678;
        @(negedge clock);
        n_checks++; if (mem_we !== 1'b1) begin n_errors++; $display("FAIL wr_serve_we got %b want 1", mem_we); end
        n_checks++; if (mem_addr !== 10'h3FF) begin n_errors++; $display("FAIL wr_serve_addr got %h want 3ff", mem_addr); end
        n_checks++; if (mem_wd !== 32'h12345678) begin n_errors++; $display("FAIL wr_serve_wd got %h want 12345678", mem_wd); end
        @(negedge clock);
        n_checks++; if (m1_ack !== 1'b1) begin n_errors++; $display("FAIL wr_m1_ack got %b want 1", m1_ack); end
        n_checks++; if (mem_we !== 1'b0) begin n_errors++; $display("FAIL wr_done_we got %b want 0", mem_we); end
        n_checks++; if (ram[10'h3FF] !== 32'h12345678) begin n_errors++; $display("FAIL wr_ram got %h want 12345678", ram[10'h3FF]); end
        m1_req = 1'b0;
        @(negedge clock);
        m1_req = 1'b1; m1_we = 1'b0;
        @(negedge clock);
        n_checks++; if (mem_we !== 1'b0) begin n_errors++; $display("FAIL rb_serve_we got %b want 0", mem_we); end
        @(negedge clock);
        n_checks++; if (m1_ack !== 1'b1) begin n_errors++; $display("FAIL rb_m1_ack got %b want 1", m1_ack); end
        n_checks++; if (m1_rd !== 32'h12345678) begin n_errors++; $display("FAIL rb_m1_rd got %h want 12345678", m1_rd); end
        m1_req = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_contention();
        logic e0, e1;
        do_reset();
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 10'd1;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 10'd2;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clock);
            e0 = (c % 3 == 2) && ((c / 3) % 2 == 0);
            e1 = (c % 3 == 2) && ((c / 3) % 2 == 1);
            n_checks++; if (m0_ack !== e0) begin n_errors++; $display("FAIL cont_m0_ack c=%0d got %b want %b", c, m0_ack, e0); end
            n_checks++; if (m1_ack !== e1) begin n_errors++; $display("FAIL cont_m1_ack c=%0d got %b want %b", c, m1_ack, e1); end
        end
        m0_req = 1'b0; m1_req = 1'b0;
        repeat (3) @(negedge clock);
    endtask

    task automatic test_reset_mid_write();
        do_reset();
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 10'd7; m0_wd = 32'hA5A5A5A5;
        @(negedge clock);
        n_checks++; if (mem_we !== 1'b1) begin n_errors++; $display("FAIL rmw_serve_we got %b want 1", mem_we); end
        #2 reset = 1'b1;
        #1;
        n_checks++; if (mem_we !== 1'b0) begin n_errors++; $display("FAIL rmw_async_we got %b want 0", mem_we); end
        n_checks++; if (mem_addr !== 10'h0) begin n_errors++; $display("FAIL rmw_async_addr got %h want 0", mem_addr); end
        @(negedge clock);
        m0_req = 1'b0;
        n_checks++; if (ram[7] !== 32'h0) begin n_errors++; $display("FAIL rmw_ram7 got %h want 0", ram[7]); end
        n_checks++; if (m1_rd !== 32'h0) begin n_errors++; $display("FAIL rmw_m1_rd got %h want 0", m1_rd); end
        n_checks++; if (mem_wd !== 32'h0) begin n_errors++; $display("FAIL rmw_mem_wd got %h want 0", mem_wd); end
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            n_checks++; if ((m0_ack | m1_ack) !== 1'b0) begin n_errors++; $display("FAIL rmw_no_ack c=%0d got %b%b want 00", c, m0_ack, m1_ack); end
        end
    endtask

    task automatic test_idle();
        do_reset();
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            n_checks++;
            if ({mem_we, mem_addr, m0_ack, m1_ack} !== 13'h0) begin
                n_errors++;
                $display("FAIL idle c=%0d got we=%b addr=%h ack=%b%b want all 0", c, mem_we, mem_addr, m0_ack, m1_ack);
            end
        end
    endtask

`ifdef DMEM_ARB_LOCK_EN
    task automatic test_lock();
        logic e0, e1;
        do_reset();
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 10'd3; m0_lock = 1'b1;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 10'd4;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clock);
            e0 = (c == 2) || (c == 5) || (c == 8);
            e1 = (c == 11);
            n_checks++; if (m0_ack !== e0) begin n_errors++; $display("FAIL lock_m0_ack c=%0d got %b want %b", c, m0_ack, e0); end
            n_checks++; if (m1_ack !== e1) begin n_errors++; $display("FAIL lock_m1_ack c=%0d got %b want %b", c, m1_ack, e1); end
            if (c == 8) m0_lock = 1'b0;
        end
        m0_req = 1'b0; m1_req = 1'b0;
        repeat (3) @(negedge clock);
    endtask
`endif

    // Transaction-level model: one access per 3 cycles, winner chosen by round robin.
    task automatic test_random();
        int          ack_cyc, serve_cyc, free_cyc;
        logic        mlast, mp, mwe, srv, ack_now;
        logic [9:0]  maddr;
        logic [31:0] mwd, rdval, erd0, erd1;
        logic [31:0] mdl [1024];
        do_reset();
        mdl = ram;
        ack_cyc = -10; serve_cyc = -10; free_cyc = 0;
        mlast = 1'b1; mp = 1'b0; mwe = 1'b0; maddr = '0; mwd = '0; rdval = '0;
        erd0 = '0; erd1 = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clock);
            ack_now = (cyc == ack_cyc);
            srv     = (cyc == serve_cyc);
            if (ack_now && !mwe) begin
                if (mp) erd1 = rdval; else erd0 = rdval;
            end
            n_checks++; if (m0_ack !== (ack_now && !mp)) begin n_errors++; $display("FAIL rnd_m0_ack c=%0d got %b want %b", cyc, m0_ack, ack_now && !mp); end
            n_checks++; if (m1_ack !== (ack_now && mp)) begin n_errors++; $display("FAIL rnd_m1_ack c=%0d got %b want %b", cyc, m1_ack, ack_now && mp); end
            n_checks++; if (mem_we !== (srv && mwe)) begin n_errors++; $display("FAIL rnd_mem_we c=%0d got %b want %b", cyc, mem_we, srv && mwe); end
            n_checks++; if (mem_addr !== (srv ? maddr : 10'h0)) begin n_errors++; $display("FAIL rnd_mem_addr c=%0d got %h want %h", cyc, mem_addr, srv ? maddr : 10'h0); end
            n_checks++; if (mem_wd !== (srv ? mwd : 32'h0)) begin n_errors++; $display("FAIL rnd_mem_wd c=%0d got %h want %h", cyc, mem_wd, srv ? mwd : 32'h0); end
            n_checks++; if (m0_rd !== erd0) begin n_errors++; $display("FAIL rnd_m0_rd c=%0d got %h want %h", cyc, m0_rd, erd0); end
            n_checks++; if (m1_rd !== erd1) begin n_errors++; $display("FAIL rnd_m1_rd c=%0d got %h want %h", cyc, m1_rd, erd1); end

            if (ack_now) begin
                if (mp) m1_req = 1'b0; else m0_req = 1'b0;
            end
            if (!m0_req && !(ack_now && !mp) && ($urandom_range(1, 0) == 1)) begin
                m0_req  = 1'b1;
                m0_we   = 1'($urandom_range(1, 0));
                m0_addr = ($urandom_range(7, 0) == 0) ? 10'h3FF : 10'($urandom_range(15, 0));
                m0_wd   = $urandom;
            end
            if (!m1_req && !(ack_now && mp) && ($urandom_range(1, 0) == 1)) begin
                m1_req  = 1'b1;
                m1_we   = 1'($urandom_range(1, 0));
                m1_addr = ($urandom_range(7, 0) == 0) ? 10'h3FF : 10'($urandom_range(15, 0));
                m1_wd   = $urandom;
            end

            if (cyc >= free_cyc && (m0_req || m1_req)) begin
                if (m0_req && m1_req) mp = ~mlast;
                else                  mp = m1_req;
                mlast = mp;
                mwe   = mp ? m1_we   : m0_we;
                maddr = mp ? m1_addr : m0_addr;
                mwd   = mp ? m1_wd   : m0_wd;
                if (mwe) mdl[maddr] = mwd;
                else     rdval = mdl[maddr];
                serve_cyc = cyc + 1;
                ack_cyc   = cyc + 2;
                free_cyc  = cyc + 3;
            end
        end
        m0_req = 1'b0; m1_req = 1'b0;
        repeat (3) @(negedge clock);
    endtask

    initial begin
        n_checks = 0; n_errors = 0;
        reset = 1'b1;
        m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wd = '0;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wd = '0;
        m0_lock = 1'b0; m1_lock = 1'b0;
        test_reset();
        test_read_after_reset();
        test_write_read();
        test_contention();
        test_reset_mid_write();
        test_idle();
`ifdef DMEM_ARB_LOCK_EN
        test_lock();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
